// File: rtl/dbg_reg_reader_pkg.sv
// dbg_reg_reader_pkg
//
// Shared definitions for the register-file debug reader:
//   - DBG_NREGS / DBG_ADRS_W / DBG_DATA_W : parameter defaults for dbg_reg_reader
//   - IDX_W                               : width of the dump index (covers up to 34 words)
//   - dbgr_state_e                        : reader FSM state encoding
//   - settle_cnt_w()                      : width of the inline settle down-counter
package dbg_reg_reader_pkg;

    localparam int unsigned DBG_NREGS  = 32;
    localparam int unsigned DBG_ADRS_W = 5;
    localparam int unsigned DBG_DATA_W = 32;

    // Largest dump is NREGS (32) + pc + inst = 34 words, so 6 bits never wrap.
    localparam int unsigned IDX_W = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StOffer  = 2'd2
    } dbgr_state_e;

    // The counter is loaded with SETTLE-1, so it needs ceil(log2(SETTLE)) bits,
    // with a floor of one bit so SETTLE=1 still gets a real (always-zero) register.
    function automatic int unsigned settle_cnt_w(input int unsigned settle);
        int unsigned w;
        w = $clog2(settle);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dbg_reg_reader.sv
// dbg_reg_reader
//
// Walks the CPU register-file debug port on request and streams every register
// out over a valid/ready interface. On a 'start' pulse (seen only while idle) the
// reader drives dbg_reg_adrs = 0, waits SETTLE cycles for the register file to
// respond, captures dbg_reg_q and offers it on out_*. Each accepted word moves the
// address on to the next register; after the final word is accepted 'done'
// pulses for one cycle and the reader returns to idle.
//
// Optional feature (macro DBG_READER_PC_EN): two extra words follow the
// registers, pc at index NREGS and inst at index NREGS+1. Without the macro the
// pc/inst inputs are present but ignored.
//
// Parameters:
//   NREGS  - registers dumped (1..32)
//   ADRS_W - width of dbg_reg_adrs
//   DATA_W - register / output word width
//   SETTLE - cycles the address is held before sampling (>= 1)
//
// Ports:
//   clk_cpu      in   CPU clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   start        in   dump request, sampled only while idle
//   dbg_reg_adrs out  address to the CPU debug read port
//   dbg_reg_q    in   register value returned for dbg_reg_adrs
//   pc           in   CPU program counter (macro builds only)
//   inst         in   current instruction (macro builds only)
//   out_valid    out  out_data/out_idx/out_last are valid
//   out_ready    in   consumer accepts the offered word
//   out_data     out  captured word
//   out_idx      out  word index within the dump
//   out_last     out  offered word is the final one
//   busy         out  dump in progress
//   done         out  one-cycle pulse after the final word is accepted
module dbg_reg_reader
    import dbg_reg_reader_pkg::*;
#(
    parameter int unsigned NREGS  = DBG_NREGS,
    parameter int unsigned ADRS_W = DBG_ADRS_W,
    parameter int unsigned DATA_W = DBG_DATA_W,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              start,
    output logic [ADRS_W-1:0] dbg_reg_adrs,
    input  logic [DATA_W-1:0] dbg_reg_q,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = settle_cnt_w(SETTLE);

`ifdef DBG_READER_PC_EN
    localparam int unsigned NWORDS = NREGS + 2;
`else
    localparam int unsigned NWORDS = NREGS;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] ADRS_MAX = IDX_W'(NREGS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    dbgr_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] src_word;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  adrs_next;

    // out_idx doubles as the dump index register.
    assign idx_next = out_idx + 1'b1;

    // The pc/inst words have no register address; keep the port parked on the
    // last register rather than walking off the end of the file.
    assign adrs_next = (idx_next > ADRS_MAX) ? ADRS_MAX : idx_next;

    // Word captured at the end of the settle phase.
    always_comb begin
        src_word = dbg_reg_q;
`ifdef DBG_READER_PC_EN
        if (out_idx == IDX_W'(NREGS)) begin
            src_word = DATA_W'(pc);
        end else if (out_idx == IDX_W'(NREGS + 1)) begin
            src_word = DATA_W'(inst);
        end
`endif
    end

`ifndef DBG_READER_PC_EN
    logic unused_pc_inst;
    assign unused_pc_inst = ^{pc, inst};
`endif

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dbg_reg_adrs <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StSettle;
                        out_idx      <= '0;
                        dbg_reg_adrs <= '0;
                        cnt_q        <= CNT_LOAD;
                        busy         <= 1'b1;
                    end
                end

                StSettle: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        out_data  <= src_word;
                        out_valid <= 1'b1;
                        out_last  <= (out_idx == LAST_IDX);
                        state_q   <= StOffer;
                    end
                end

                StOffer: begin
                    // out_valid is always high here, so out_ready alone marks a transfer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            out_idx      <= idx_next;
                            dbg_reg_adrs <= ADRS_W'(adrs_next);
                            cnt_q        <= CNT_LOAD;
                            state_q      <= StSettle;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_reg_reader.sv
module tb_dbg_reg_reader;
    import dbg_reg_reader_pkg::*;

`ifdef DBG_READER_PC_EN
    localparam int NW = 34;
`else
    localparam int NW = 32;
`endif

    localparam logic [31:0] PC_VAL   = 32'h0040_0020;
    localparam logic [31:0] INST_VAL = 32'h8C08_0004;

    logic        clk_cpu = 1'b0;
    logic        reset   = 1'b1;

    // DUT with SETTLE=1 and a combinational register file.
    logic        start = 1'b0;
    logic [4:0]  dbg_reg_adrs;
    logic [31:0] dbg_reg_q;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last, busy, done;

    // DUT with SETTLE=3 and a two-cycle register file.
    logic        start3 = 1'b0;
    logic [4:0]  adrs3, a3_d1, a3_d2;
    logic [31:0] q3;
    logic        valid3, ready3 = 1'b1;
    logic [31:0] data3;
    logic [5:0]  idx3;
    logic        last3, busy3, done3;

    logic [31:0] pc   = PC_VAL;
    logic [31:0] inst = INST_VAL;

    int checks = 0;
    int errors = 0;

    always #5 clk_cpu = ~clk_cpu;

    assign dbg_reg_q = 32'h1000_0000 + {27'd0, dbg_reg_adrs};

    always @(posedge clk_cpu) begin
        a3_d1 <= adrs3;
        a3_d2 <= a3_d1;
    end
    assign q3 = 32'h2000_0000 + {27'd0, a3_d2};

    dbg_reg_reader #(.NREGS(32), .ADRS_W(5), .DATA_W(32), .SETTLE(1)) u_dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .start        (start),
        .dbg_reg_adrs (dbg_reg_adrs),
        .dbg_reg_q    (dbg_reg_q),
        .pc           (pc),
        .inst         (inst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    dbg_reg_reader #(.NREGS(32), .ADRS_W(5), .DATA_W(32), .SETTLE(3)) u_dut3 (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .start        (start3),
        .dbg_reg_adrs (adrs3),
        .dbg_reg_q    (q3),
        .pc           (pc),
        .inst         (inst),
        .out_valid    (valid3),
        .out_ready    (ready3),
        .out_data     (data3),
        .out_idx      (idx3),
        .out_last     (last3),
        .busy         (busy3),
        .done         (done3)
    );

    function automatic logic [31:0] exp_word(input int idx, input logic [31:0] base);
        if (idx < 32) return base + 32'(idx);
        else if (idx == 32) return PC_VAL;
        else return INST_VAL;
    endfunction

    task automatic pulse_start();
        @(negedge clk_cpu);
        start = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        start3 = 1'b1;
        repeat (10) @(negedge clk_cpu);
        checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 0000", {out_valid, out_last, busy, done});
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 00000000", out_data);
        end
        checks++;
        if ({out_idx, dbg_reg_adrs} !== 11'h0) begin
            errors++;
            $display("FAIL reset_idx_adrs: got %h/%h, expected 0/0", out_idx, dbg_reg_adrs);
        end
        start = 1'b0;
        start3 = 1'b0;
        @(negedge clk_cpu);
        reset = 1'b0;
        repeat (5) @(negedge clk_cpu);
        checks++;
        if ({busy, out_valid, busy3, valid3} !== 4'b0) begin
            errors++;
            $display("FAIL reset_no_dump: got %b, expected 0000", {busy, out_valid, busy3, valid3});
        end
    endtask

    task automatic test_free_flow();
        int words, lasts, done_k;
        words = 0; lasts = 0; done_k = -1;
        out_ready = 1'b1;
        pulse_start();
        checks++;
        if ({busy, out_valid, dbg_reg_adrs} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL ff_start: got busy=%b valid=%b adrs=%0d, expected 1 0 0",
                     busy, out_valid, dbg_reg_adrs);
        end
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_cpu);
            if (out_valid && out_ready) begin
                checks++;
                if ({out_idx, out_data, out_last} !==
                    {6'(words), exp_word(words, 32'h1000_0000), (words == NW - 1)}) begin
                    errors++;
                    $display("FAIL ff_word: got idx=%0d data=%h last=%b, expected %0d %h %b",
                             out_idx, out_data, out_last, words,
                             exp_word(words, 32'h1000_0000), (words == NW - 1));
                end
                if (out_last) lasts++;
                words++;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        checks++;
        if (done_k != NW * 2) begin
            errors++;
            $display("FAIL ff_done_latency: got %0d, expected %0d", done_k, NW * 2);
        end
        checks++;
        if (words != NW || lasts != 1) begin
            errors++;
            $display("FAIL ff_count: got words=%0d lasts=%0d, expected %0d 1", words, lasts, NW);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ff_busy_after: got %b, expected 0", busy);
        end
        @(negedge clk_cpu);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ff_done_pulse: got %b, expected 0", done);
        end
    endtask

    task automatic test_backpressure();
        int words;
        bit stalled, seen_done;
        words = 0; stalled = 0; seen_done = 0;
        out_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_cpu);
            if (out_valid && out_idx == 6'd3 && !stalled) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk_cpu);
                    checks++;
                    if ({out_valid, out_idx, out_data, dbg_reg_adrs} !==
                        {1'b1, 6'd3, 32'h1000_0003, 5'd3}) begin
                        errors++;
                        $display("FAIL bp_hold: got v=%b idx=%0d data=%h adrs=%0d, expected 1 3 10000003 3",
                                 out_valid, out_idx, out_data, dbg_reg_adrs);
                    end
                end
                out_ready = 1'b1;
                stalled = 1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({out_idx, out_data} !== {6'(words), exp_word(words, 32'h1000_0000)}) begin
                    errors++;
                    $display("FAIL bp_word: got idx=%0d data=%h, expected %0d %h",
                             out_idx, out_data, words, exp_word(words, 32'h1000_0000));
                end
                words++;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        checks++;
        if (!seen_done || words != NW) begin
            errors++;
            $display("FAIL bp_count: got done=%0d words=%0d, expected 1 %0d", seen_done, words, NW);
        end
    endtask

    task automatic test_start_busy_reset();
        int words;
        bit bad, seen_first, seen_done;
        words = 0; bad = 0; seen_first = 0; seen_done = 0;
        out_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_cpu);
            start = 1'b0;
            if (done) bad = 1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_idx !== 6'(words)) begin
                    errors++;
                    $display("FAIL sbr_idx: got %0d, expected %0d", out_idx, words);
                end
                if (out_idx == 6'd5) start = 1'b1;
                if (out_idx == 6'd10) begin
                    reset = 1'b1;
                    #1;
                    checks++;
                    if ({out_valid, out_last, busy, done, out_idx, dbg_reg_adrs, out_data} !== '0) begin
                        errors++;
                        $display("FAIL sbr_reset_outputs: got v=%b busy=%b idx=%0d adrs=%0d data=%h, expected all 0",
                                 out_valid, busy, out_idx, dbg_reg_adrs, out_data);
                    end
                    break;
                end
                words++;
            end
        end
        checks++;
        if (bad || words != 10) begin
            errors++;
            $display("FAIL sbr_before_reset: got early_done=%0d words=%0d, expected 0 10", bad, words);
        end
        repeat (2) @(negedge clk_cpu);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_cpu);
            if (out_valid || done || busy) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL sbr_quiet_after_reset: got activity=1, expected 0");
        end
        pulse_start();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_cpu);
            if (out_valid && !seen_first) begin
                seen_first = 1;
                checks++;
                if ({out_idx, out_data} !== {6'd0, 32'h1000_0000}) begin
                    errors++;
                    $display("FAIL sbr_restart: got idx=%0d data=%h, expected 0 10000000",
                             out_idx, out_data);
                end
            end
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        checks++;
        if (!seen_first || !seen_done) begin
            errors++;
            $display("FAIL sbr_restart_done: got first=%0d done=%0d, expected 1 1", seen_first, seen_done);
        end
    endtask

    task automatic test_settle3();
        int words, prev_k, done_k;
        words = 0; prev_k = 0; done_k = -1;
        ready3 = 1'b1;
        @(negedge clk_cpu);
        start3 = 1'b1;
        @(negedge clk_cpu);
        start3 = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk_cpu);
            if (valid3) begin
                checks++;
                if ({idx3, data3} !== {6'(words), exp_word(words, 32'h2000_0000)}) begin
                    errors++;
                    $display("FAIL s3_word: got idx=%0d data=%h, expected %0d %h",
                             idx3, data3, words, exp_word(words, 32'h2000_0000));
                end
                checks++;
                if ((words == 0 && k != 3) || (words != 0 && k - prev_k != 4)) begin
                    errors++;
                    $display("FAIL s3_period: got k=%0d prev=%0d at word %0d, expected first 3 then step 4",
                             k, prev_k, words);
                end
                prev_k = k;
                words++;
            end
            if (done3) begin
                done_k = k;
                break;
            end
        end
        checks++;
        if (done_k != NW * 4 || words != NW) begin
            errors++;
            $display("FAIL s3_done: got k=%0d words=%0d, expected %0d %0d", done_k, words, NW * 4, NW);
        end
    endtask

`ifdef DBG_READER_PC_EN
    task automatic test_pc_words();
        int words;
        logic [31:0] w32, w33;
        logic l32, l33;
        words = 0; w32 = '0; w33 = '0; l32 = 1'b1; l33 = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_cpu);
            if (out_valid) begin
                if (out_idx == 6'd32) begin w32 = out_data; l32 = out_last; end
                if (out_idx == 6'd33) begin w33 = out_data; l33 = out_last; end
                words++;
            end
            if (done) break;
        end
        checks++;
        if ({w32, w33} !== {PC_VAL, INST_VAL}) begin
            errors++;
            $display("FAIL pc_words: got %h %h, expected %h %h", w32, w33, PC_VAL, INST_VAL);
        end
        checks++;
        if ({l32, l33} !== 2'b01 || words != 34) begin
            errors++;
            $display("FAIL pc_last_count: got last=%b%b words=%0d, expected 01 34", l32, l33, words);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_free_flow();
        test_backpressure();
        test_start_busy_reset();
        test_settle3();
`ifdef DBG_READER_PC_EN
        test_pc_words();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
